// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: upstream instr/EXTOp channel and downstream immediate channel.
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [2:0]      EXTOp;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] immout;
  logic            imm_illegal;

  modport master (
    output in_valid, instr, EXTOp, out_ready,
    input  in_ready, out_valid, immout, imm_illegal
  );

  modport slave (
    input  in_valid, instr, EXTOp, out_ready,
    output in_ready, out_valid, immout, imm_illegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator behind a 2-entry skid buffer (output register + skid register).
// Optional macro IMM_GEN_ZIMM_EN enables EXTOp 110 as the zero-extended CSR zimm field.
module imm_gen_pipe #(
  parameter int unsigned XLEN = 32
) (
  input logic             clk,
  input logic             rst,
  input logic             flush,
  imm_gen_pipe_if.slave   bus
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d;
  logic            out_ill_q, out_ill_d;
  logic [XLEN-1:0] skid_imm_q, skid_imm_d;
  logic            skid_ill_q, skid_ill_d;

  logic signed [31:0] imm32;
  logic               dec_ill;
  logic [XLEN-1:0]    dec_imm;
  logic               in_ready, out_valid, in_fire, out_fire;

  // Opcode bits never feed any immediate field.
  logic unused_opcode;
  assign unused_opcode = ^bus.instr[6:0];

  always_comb begin
    imm32   = '0;
    dec_ill = 1'b0;
    unique case (bus.EXTOp)
      3'b001: imm32 = {{20{bus.instr[31]}}, bus.instr[31:20]};
      3'b010: imm32 = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
      3'b011: imm32 = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7], bus.instr[30:25],
                       bus.instr[11:8], 1'b0};
      3'b100: imm32 = {bus.instr[31:12], 12'b0};
      3'b101: imm32 = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12], bus.instr[20],
                       bus.instr[30:21], 1'b0};
`ifdef IMM_GEN_ZIMM_EN
      3'b110: imm32 = {27'b0, bus.instr[19:15]};
`else
      3'b110: dec_ill = 1'b1;
`endif
      default: dec_ill = 1'b1;
    endcase
  end

  // Signed cast widens to XLEN; zimm has a zero MSB so it stays zero-extended.
  assign dec_imm = XLEN'(imm32);

  // Ready depends on registered state only, so no out_ready -> in_ready path exists.
  assign in_ready  = (state_q != StTwo);
  assign out_valid = (state_q == StOne) || (state_q == StTwo);
  assign in_fire   = bus.in_valid && in_ready;
  assign out_fire  = out_valid && bus.out_ready;

  always_comb begin
    state_d    = state_q;
    out_imm_d  = out_imm_q;
    out_ill_d  = out_ill_q;
    skid_imm_d = skid_imm_q;
    skid_ill_d = skid_ill_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_d   = StOne;
            out_imm_d = dec_imm;
            out_ill_d = dec_ill;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            out_imm_d = dec_imm;
            out_ill_d = dec_ill;
          end else if (in_fire) begin
            state_d    = StTwo;
            skid_imm_d = dec_imm;
            skid_ill_d = dec_ill;
          end else if (out_fire) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (out_fire) begin
            state_d   = StOne;
            out_imm_d = skid_imm_q;
            out_ill_d = skid_ill_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StEmpty;
      out_imm_q  <= '0;
      out_ill_q  <= 1'b0;
      skid_imm_q <= '0;
      skid_ill_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_imm_q  <= out_imm_d;
      out_ill_q  <= out_ill_d;
      skid_imm_q <= skid_imm_d;
      skid_ill_q <= skid_ill_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.immout      = out_imm_q;
  assign bus.imm_illegal = out_ill_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe; one XLEN=32 and one XLEN=64 instance.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32)) bus_a ();
  imm_gen_pipe_if #(.XLEN(64)) bus_b ();

  imm_gen_pipe #(.XLEN(32)) u_dut32 (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus_a)
  );

  imm_gen_pipe #(.XLEN(64)) u_dut64 (
    .clk   (clk),
    .rst   (rst),
    .flush (1'b0),
    .bus   (bus_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [31:0] ins, input logic [2:0] op);
    bus_a.in_valid = 1'b1;
    bus_a.instr    = ins;
    bus_a.EXTOp    = op;
    step();
    bus_a.in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] ins, input logic [2:0] op);
    bus_b.in_valid = 1'b1;
    bus_b.instr    = ins;
    bus_b.EXTOp    = op;
    step();
    bus_b.in_valid = 1'b0;
  endtask

  // Single accept with out_ready=1, check the entry, then let it drain.
  task automatic one_a(input string tag, input logic [31:0] ins, input logic [2:0] op,
                       input logic [31:0] exp_imm, input logic exp_ill);
    bus_a.out_ready = 1'b1;
    send_a(ins, op);
    check({tag, "_vld"}, 64'(bus_a.out_valid), 64'd1);
    check({tag, "_imm"}, 64'(bus_a.immout), 64'(exp_imm));
    check({tag, "_ill"}, 64'(bus_a.imm_illegal), 64'(exp_ill));
    step();
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.instr = '0; bus_a.EXTOp = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.instr = '0; bus_b.EXTOp = '0; bus_b.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;

    check("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus_a.in_ready), 64'd1);
    check("rst_immout", 64'(bus_a.immout), 64'd0);
    check("rst_illegal", 64'(bus_a.imm_illegal), 64'd0);

    // I-type -1, one-cycle latency, then drain
    bus_a.out_ready = 1'b1;
    send_a(32'hFFF00093, 3'b001);
    check("i_neg_vld", 64'(bus_a.out_valid), 64'd1);
    check("i_neg_imm", 64'(bus_a.immout), 64'hFFFF_FFFF);
    check("i_neg_ill", 64'(bus_a.imm_illegal), 64'd0);
    step();
    check("i_neg_drain", 64'(bus_a.out_valid), 64'd0);

    one_a("i_pos", 32'h7FF00093, 3'b001, 32'h0000_07FF, 1'b0);
    one_a("u32", 32'h123452B7, 3'b100, 32'h1234_5000, 1'b0);
    one_a("op000", 32'hFFFFFFFF, 3'b000, 32'h0, 1'b1);
    one_a("op111", 32'hFFFFFFFF, 3'b111, 32'h0, 1'b1);
`ifdef IMM_GEN_ZIMM_EN
    one_a("zimm", 32'h000A8073, 3'b110, 32'h0000_0015, 1'b0);
`else
    one_a("zimm", 32'h000A8073, 3'b110, 32'h0, 1'b1);
`endif

    // S then B back-to-back with downstream stalled
    bus_a.out_ready = 1'b0;
    send_a(32'hFE20AE23, 3'b010);
    check("sb_ready_one", 64'(bus_a.in_ready), 64'd1);
    send_a(32'hFE000CE3, 3'b011);
    check("sb_ready_two", 64'(bus_a.in_ready), 64'd0);
    check("sb_first_imm", 64'(bus_a.immout), 64'hFFFF_FFFC);
    step();
    check("sb_hold_imm", 64'(bus_a.immout), 64'hFFFF_FFFC);
    check("sb_hold_vld", 64'(bus_a.out_valid), 64'd1);
    bus_a.out_ready = 1'b1;
    step();
    check("sb_second_imm", 64'(bus_a.immout), 64'hFFFF_FFF8);
    check("sb_second_vld", 64'(bus_a.out_valid), 64'd1);
    check("sb_second_rdy", 64'(bus_a.in_ready), 64'd1);
    step();
    check("sb_drained", 64'(bus_a.out_valid), 64'd0);

    // J-type, simultaneous in/out transfer while in ONE
    bus_a.in_valid = 1'b1;
    bus_a.instr    = 32'h0080006F;
    bus_a.EXTOp    = 3'b101;
    step();
    check("j_pos_imm", 64'(bus_a.immout), 64'h8);
    bus_a.instr = 32'hFFDFF06F;
    step();
    bus_a.in_valid = 1'b0;
    check("j_neg_imm", 64'(bus_a.immout), 64'hFFFF_FFFC);
    check("j_neg_vld", 64'(bus_a.out_valid), 64'd1);
    step();
    check("j_drained", 64'(bus_a.out_valid), 64'd0);

    // Flush in TWO with a same-cycle input
    bus_a.out_ready = 1'b0;
    send_a(32'h00100093, 3'b001);
    send_a(32'h00200093, 3'b001);
    check("fl_full", 64'(bus_a.in_ready), 64'd0);
    flush = 1'b1;
    bus_a.in_valid = 1'b1;
    bus_a.instr    = 32'h00300093;
    step();
    flush = 1'b0;
    bus_a.in_valid = 1'b0;
    check("fl_out_valid", 64'(bus_a.out_valid), 64'd0);
    check("fl_in_ready", 64'(bus_a.in_ready), 64'd1);
    bus_a.out_ready = 1'b1;
    step();
    step();
    check("fl_no_emerge", 64'(bus_a.out_valid), 64'd0);
    one_a("fl_after", 32'h00400093, 3'b001, 32'h4, 1'b0);

    // Reset in TWO overrides flush and handshakes
    bus_a.out_ready = 1'b0;
    send_a(32'hFFF00093, 3'b001);
    send_a(32'h00500093, 3'b000);
    rst   = 1'b1;
    flush = 1'b1;
    bus_a.in_valid  = 1'b1;
    bus_a.out_ready = 1'b1;
    step();
    rst   = 1'b0;
    flush = 1'b0;
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b0;
    check("rst2_out_valid", 64'(bus_a.out_valid), 64'd0);
    check("rst2_in_ready", 64'(bus_a.in_ready), 64'd1);
    check("rst2_immout", 64'(bus_a.immout), 64'd0);
    check("rst2_illegal", 64'(bus_a.imm_illegal), 64'd0);

    // XLEN=64 sign extension
    bus_b.out_ready = 1'b1;
    send_b(32'h123452B7, 3'b100);
    check("u64_pos_vld", 64'(bus_b.out_valid), 64'd1);
    check("u64_pos_imm", bus_b.immout, 64'h0000_0000_1234_5000);
    send_b(32'h800002B7, 3'b100);
    check("u64_neg_imm", bus_b.immout, 64'hFFFF_FFFF_8000_0000);
    send_b(32'hFFF00093, 3'b001);
    check("i64_neg_imm", bus_b.immout, 64'hFFFF_FFFF_FFFF_FFFF);
    send_b(32'hFE000CE3, 3'b011);
    check("b64_neg_imm", bus_b.immout, 64'hFFFF_FFFF_FFFF_FFF8);
    step();
    check("b64_drained", 64'(bus_b.out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width of immout; legal values 32 and 64.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 flush  input  1  synchronous pipeline clear, active-high.
REQ-005 in_valid  input  1  upstream presents instr/EXTOp.
REQ-006 in_ready  output  1  block can accept an input this cycle.
REQ-007 instr  input  32  complete instruction word.
REQ-008 EXTOp  input  3  immediate format select.
REQ-009 out_valid  output  1  immout/imm_illegal are valid.
REQ-010 out_ready  input  1  downstream accepts the output this cycle.
REQ-011 immout  output  XLEN  extended immediate.
REQ-012 imm_illegal  output  1  EXTOp was unsupported for this entry.

Function
REQ-013 The input transfer SHALL occur when in_valid and in_ready are both 1; the output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-014 EXTOp decode: 000 zero; 001 I {instr[31:20]}; 010 S {instr[31:25],instr[11:7]}; 011 B {instr[31],instr[7],instr[30:25],instr[11:8],0}; 100 U {instr[31:12],12'b0}; 101 J {instr[31],instr[19:12],instr[20],instr[30:21],0}; 110 ZIMM (see Configuration); 111 zero.
REQ-015 Each I/S/B/U/J field SHALL be sign-extended from its MSB to XLEN bits (U from instr[31] when XLEN=64).
REQ-016 EXTOp 000 and 111 SHALL give immout=0 with imm_illegal=1; all supported codes give imm_illegal=0.
REQ-017 Storage SHALL be a 2-entry buffer (output register plus skid register) with states EMPTY, ONE, TWO.
REQ-018 EMPTY: input transfer -> ONE, output register loaded; otherwise stay.
REQ-019 ONE: input and output transfer together -> ONE with new entry; input only -> TWO, skid loaded; output only -> EMPTY.
REQ-020 TWO: output transfer -> ONE, output register loaded from skid; no input accepted.
REQ-021 in_ready SHALL be 1 exactly when state is not TWO, decoded from registered state only (no combinational path from out_ready).
REQ-022 out_valid SHALL be 1 exactly when state is ONE or TWO.
REQ-023 Latency SHALL be one cycle: an input accepted at edge N is visible on immout after edge N when the buffer was EMPTY.
REQ-024 Outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 Entries SHALL leave in acceptance order; no entry is duplicated or dropped except by flush/rst.
REQ-026 flush SHALL take priority over all transfers: next state EMPTY, any same-cycle input discarded, out_valid=0 and in_ready=1 on the following cycle.

Reset
REQ-027 On rst at a clock edge: state EMPTY, out_valid=0, immout=0, imm_illegal=0, skid register cleared; in_ready=1 from the next cycle.
REQ-028 rst SHALL override flush and any handshake in the same cycle, including mid-operation in state TWO.

Configuration
REQ-029 Macro IMM_GEN_ZIMM_EN: when defined, EXTOp 110 SHALL yield zero-extended {instr[19:15]} (CSR zimm) with imm_illegal=0.
REQ-030 Without IMM_GEN_ZIMM_EN, EXTOp 110 SHALL yield immout=0 with imm_illegal=1; all other behaviour is identical.

Verification
REQ-031 instr=32'hFFF00093, EXTOp=001, out_ready=1 -> one cycle later out_valid=1, immout=32'hFFFFFFFF, imm_illegal=0.
REQ-032 Back-to-back instr=32'hFE20AE23 (S) then 32'hFE000CE3 (B), out_ready=0 -> in_ready falls to 0 after 2nd accept; raising out_ready yields 32'hFFFFFFFC then 32'hFFFFFFF8 in order.
REQ-033 instr=32'h123452B7, EXTOp=100, XLEN=64 -> immout=64'h0000000012345000; instr=32'h800002B7 -> 64'hFFFFFFFF80000000.
REQ-034 Buffer in TWO, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input never emerges.
REQ-035 instr with instr[19:15]=5'b10101, EXTOp=110 -> immout=32'h00000015, imm_illegal=0 with IMM_GEN_ZIMM_EN; immout=0, imm_illegal=1 without.
